// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder: address map constants and region decode.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_JOY1,
    RGN_JOY2,
    RGN_ROM,
    RGN_OPEN
  } region_e;

  localparam logic [15:0] RAM_TOP   = 16'h1FFF;
  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;
  localparam logic [15:0] ROM_BASE  = 16'h8000;

  // Priority decode of a CPU address into the region that serves it.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e rgn;
    if (addr <= RAM_TOP)         rgn = RGN_RAM;
    else if (addr == JOY1_ADDR)  rgn = RGN_JOY1;
    else if (addr == JOY2_ADDR)  rgn = RGN_JOY2;
    else if (addr >= ROM_BASE)   rgn = RGN_ROM;
    else                         rgn = RGN_OPEN;
    return rgn;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_joypad_shifter.sv
// Serial joypad port: parallel button capture while strobed, shift-out on reads otherwise.
module joypad_shifter #(
  parameter int unsigned JOY_BITS = 8
) (
  input  logic                clk_ph2,
  input  logic                rst,
  input  logic                strobe,
  input  logic                rd,
  input  logic [JOY_BITS-1:0] buttons,
  output logic                serial_out
);

  logic [JOY_BITS-1:0] shift_q;

  // Reload every cycle while strobed; otherwise each read shifts right, filling with ones.
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      shift_q <= '1;
    end else if (strobe) begin
      shift_q <= buttons;
    end else if (rd) begin
      shift_q <= {1'b1, shift_q[JOY_BITS-1:1]};
    end
  end

  // While strobed the first button is seen live, not the captured copy.
  assign serial_out = strobe ? buttons[0] : shift_q[0];

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: work RAM (mirrored), two serial joypads, PRG ROM window, open bus.
module cpu_bus_responder #(
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned ROM_AW   = 15,
  parameter int unsigned JOY_BITS = 8
) (
  input  logic                clk_ph2,
  input  logic                rst,
  input  logic                bus_en,
  input  logic                rw,
  input  logic [15:0]         Addr_bus,
  input  logic [7:0]          wdata,
  output logic [7:0]          Data_bus,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [7:0]          rom_data,
  input  logic [JOY_BITS-1:0] joy1,
  input  logic [JOY_BITS-1:0] joy2
);

  import cpu_bus_pkg::*;

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  logic [7:0]        mem [RAM_DEPTH];
  logic [7:0]        open_bus;
  logic              strobe;
  logic [7:0]        rd_data;
  region_e           region;
  logic              rd_acc;
  logic              wr_acc;
  logic              joy1_bit;
  logic              joy2_bit;
  logic [RAM_AW-1:0] ram_idx;

  assign region   = decode_region(Addr_bus);
  assign rd_acc   = bus_en & rw;
  assign wr_acc   = bus_en & ~rw;
  assign ram_idx  = Addr_bus[RAM_AW-1:0];
  assign rom_addr = Addr_bus[ROM_AW-1:0];

  joypad_shifter #(.JOY_BITS(JOY_BITS)) u_joy1 (
    .clk_ph2    (clk_ph2),
    .rst        (rst),
    .strobe     (strobe),
    .rd         (rd_acc && (region == RGN_JOY1)),
    .buttons    (joy1),
    .serial_out (joy1_bit)
  );

  joypad_shifter #(.JOY_BITS(JOY_BITS)) u_joy2 (
    .clk_ph2    (clk_ph2),
    .rst        (rst),
    .strobe     (strobe),
    .rd         (rd_acc && (region == RGN_JOY2)),
    .buttons    (joy2),
    .serial_out (joy2_bit)
  );

  // Read-data selection by decoded region; unmapped space floats to the open-bus value.
  always_comb begin
    rd_data = open_bus;
    case (region)
      RGN_RAM:  rd_data = mem[ram_idx];
      RGN_JOY1: rd_data = {open_bus[7:5], 4'b0000, joy1_bit};
      RGN_JOY2: rd_data = {open_bus[7:5], 4'b0000, joy2_bit};
      RGN_ROM:  rd_data = rom_data;
      default:  rd_data = open_bus;
    endcase
  end

  // Work RAM: synchronous write, contents survive reset; a write under reset is dropped.
  always_ff @(posedge clk_ph2) begin
    if (!rst && wr_acc && (region == RGN_RAM)) begin
      mem[ram_idx] <= wdata;
    end
  end

  // Returned data, open-bus latch and joypad strobe.
  always_ff @(posedge clk_ph2 or posedge rst) begin
    if (rst) begin
      Data_bus <= 8'h00;
      open_bus <= 8'h00;
      strobe   <= 1'b0;
    end else if (rd_acc) begin
      Data_bus <= rd_data;
      open_bus <= rd_data;
    end else if (wr_acc) begin
      open_bus <= wdata;
      if (Addr_bus == JOY1_ADDR) begin
        strobe <= wdata[0];
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder against a behavioural bus model.
module tb_cpu_bus_responder;

  localparam int JB = 8;

  logic        clk_ph2 = 1'b0;
  logic        rst     = 1'b1;
  logic        bus_en  = 1'b0;
  logic        rw      = 1'b1;
  logic [15:0] Addr_bus = 16'h0000;
  logic [7:0]  wdata   = 8'h00;
  logic [7:0]  Data_bus;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  joy1 = 8'h00;
  logic [7:0]  joy2 = 8'h00;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_ram [2048];
  bit         m_ok  [2048];
  logic [7:0] m_data, m_open;
  logic       m_strobe;
  logic [7:0] snap1, snap2;
  int         cnt1, cnt2;

  always #5 clk_ph2 = ~clk_ph2;

  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h6E;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  cpu_bus_responder dut (
    .clk_ph2  (clk_ph2),
    .rst      (rst),
    .bus_en   (bus_en),
    .rw       (rw),
    .Addr_bus (Addr_bus),
    .wdata    (wdata),
    .Data_bus (Data_bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .joy1     (joy1),
    .joy2     (joy2)
  );

  task automatic model_reset();
    m_data   = 8'h00;
    m_open   = 8'h00;
    m_strobe = 1'b0;
    snap1    = 8'hFF;
    snap2    = 8'hFF;
    cnt1     = 0;
    cnt2     = 0;
  endtask

  // Drive one bus cycle and advance the model; returns #1 after the sampling edge.
  task automatic do_access(input bit en, input bit r, input logic [15:0] a, input logic [7:0] wd);
    logic [7:0] rv;
    logic       b1, b2, ns;
    @(negedge clk_ph2);
    bus_en = en; rw = r; Addr_bus = a; wdata = wd;
    b1 = m_strobe ? joy1[0] : ((cnt1 < JB) ? snap1[cnt1] : 1'b1);
    b2 = m_strobe ? joy2[0] : ((cnt2 < JB) ? snap2[cnt2] : 1'b1);
    ns = m_strobe;
    if (en && r) begin
      if (a < 16'h2000)        rv = m_ram[a[10:0]];
      else if (a == 16'h4016)  rv = {m_open[7:5], 4'b0000, b1};
      else if (a == 16'h4017)  rv = {m_open[7:5], 4'b0000, b2};
      else if (a >= 16'h8000)  rv = rom_fn(a[14:0]);
      else                     rv = m_open;
      m_data = rv;
      m_open = rv;
    end else if (en) begin
      m_open = wd;
      if (a < 16'h2000) begin
        m_ram[a[10:0]] = wd;
        m_ok[a[10:0]]  = 1'b1;
      end
      if (a == 16'h4016) ns = wd[0];
    end
    if (m_strobe) begin
      snap1 = joy1; cnt1 = 0;
      snap2 = joy2; cnt2 = 0;
    end else begin
      if (en && r && a == 16'h4016 && cnt1 < JB) cnt1++;
      if (en && r && a == 16'h4017 && cnt2 < JB) cnt2++;
    end
    m_strobe = ns;
    @(posedge clk_ph2);
    #1;
    bus_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_ph2);
    #1;
    total++;
    if (Data_bus !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=%h", Data_bus, 8'h00);
    end
    @(negedge clk_ph2);
    rst = 1'b0;
    model_reset();
    do_access(1, 1, 16'h4016, 8'h00);
    total++;
    if (Data_bus !== 8'h01) begin
      bad++; $display("FAIL reset_joy1 got=%h want=%h", Data_bus, 8'h01);
    end
    do_access(1, 1, 16'h4017, 8'h00);
    total++;
    if (Data_bus !== 8'h01) begin
      bad++; $display("FAIL reset_joy2 got=%h want=%h", Data_bus, 8'h01);
    end
    do_access(1, 1, 16'h5000, 8'h00);
    total++;
    if (Data_bus !== 8'h01) begin
      bad++; $display("FAIL reset_open got=%h want=%h", Data_bus, 8'h01);
    end
  endtask

  task automatic test_ram_mirror();
    logic [15:0] addrs [3];
    addrs[0] = 16'h0805; addrs[1] = 16'h1005; addrs[2] = 16'h1805;
    do_access(1, 0, 16'h0005, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1, addrs[i], 8'h00);
      total++;
      if (Data_bus !== 8'hA5) begin
        bad++; $display("FAIL ram_mirror addr=%h got=%h want=%h", addrs[i], Data_bus, 8'hA5);
      end
    end
    // Write then immediate read of the same location returns the new byte.
    do_access(1, 0, 16'h07FF, 8'h3C);
    do_access(1, 1, 16'h1FFF, 8'h00);
    total++;
    if (Data_bus !== 8'h3C) begin
      bad++; $display("FAIL ram_wr_rd got=%h want=%h", Data_bus, 8'h3C);
    end
  endtask

  task automatic test_joy_shift();
    logic [9:0] seq;
    seq = 10'b11_0000_0101;
    joy1 = 8'b0000_0101;
    do_access(1, 0, 16'h4016, 8'h01);
    do_access(1, 0, 16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      do_access(1, 1, 16'h4016, 8'h00);
      total++;
      if (Data_bus[0] !== seq[i] || Data_bus !== m_data) begin
        bad++; $display("FAIL joy_shift read=%0d got=%h want_bit=%b want=%h", i, Data_bus, seq[i], m_data);
      end
    end
  endtask

  task automatic test_joy_strobe_live();
    do_access(1, 0, 16'h4016, 8'h01);
    joy1 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1, 16'h4016, 8'h00);
      total++;
      if (Data_bus[0] !== 1'b1) begin
        bad++; $display("FAIL joy_strobe_hold read=%0d got=%b want=1", i, Data_bus[0]);
      end
    end
    joy1 = 8'h00;
    do_access(1, 1, 16'h4016, 8'h00);
    total++;
    if (Data_bus[0] !== 1'b0) begin
      bad++; $display("FAIL joy_strobe_live got=%b want=0", Data_bus[0]);
    end
    do_access(1, 0, 16'h4016, 8'h00);
  endtask

  task automatic test_rom_open();
    do_access(1, 1, 16'h8123, 8'h00);
    total++;
    if (Data_bus !== 8'h4C) begin
      bad++; $display("FAIL rom_read got=%h want=%h", Data_bus, 8'h4C);
    end
    do_access(1, 0, 16'h8123, 8'h4C);
    do_access(1, 1, 16'h5000, 8'h00);
    total++;
    if (Data_bus !== 8'h4C) begin
      bad++; $display("FAIL open_bus got=%h want=%h", Data_bus, 8'h4C);
    end
    do_access(1, 1, 16'h8123, 8'h00);
    total++;
    if (Data_bus !== 8'h4C) begin
      bad++; $display("FAIL rom_after_write got=%h want=%h", Data_bus, 8'h4C);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] prev;
    joy1 = 8'h00;
    joy2 = 8'hFF;
    do_access(1, 0, 16'h4016, 8'h01);
    do_access(1, 0, 16'h4016, 8'hE0);
    for (int i = 0; i < 3; i++) begin
      do_access(1, 1, 16'h4017, 8'h00);
      total++;
      if (Data_bus !== 8'hE1) begin
        bad++; $display("FAIL joy2_read=%0d got=%h want=%h", i, Data_bus, 8'hE1);
      end
    end
    prev = Data_bus;
    do_access(1, 1, 16'h4016, 8'h00);
    total++;
    if (Data_bus !== {prev[7:5], 5'b00000}) begin
      bad++; $display("FAIL joy1_interleave got=%h want=%h", Data_bus, {prev[7:5], 5'b00000});
    end
  endtask

  task automatic test_reset_mid();
    do_access(1, 0, 16'h0010, 8'h11);
    joy1 = 8'h01;
    do_access(1, 0, 16'h4016, 8'h01);
    do_access(1, 0, 16'h4016, 8'h00);
    do_access(1, 1, 16'h4016, 8'h00);
    total++;
    if (Data_bus !== 8'h01) begin
      bad++; $display("FAIL pre_reset_shift got=%h want=%h", Data_bus, 8'h01);
    end
    @(negedge clk_ph2);
    bus_en = 1'b1; rw = 1'b0; Addr_bus = 16'h0010; wdata = 8'h33; rst = 1'b1;
    @(posedge clk_ph2);
    #1;
    total++;
    if (Data_bus !== 8'h00) begin
      bad++; $display("FAIL reset_mid_data got=%h want=%h", Data_bus, 8'h00);
    end
    @(negedge clk_ph2);
    rst = 1'b0; bus_en = 1'b0;
    model_reset();
    do_access(1, 1, 16'h0010, 8'h00);
    total++;
    if (Data_bus !== 8'h11) begin
      bad++; $display("FAIL reset_mid_ram got=%h want=%h", Data_bus, 8'h11);
    end
    do_access(1, 1, 16'h4016, 8'h00);
    total++;
    if (Data_bus !== 8'h01) begin
      bad++; $display("FAIL reset_mid_joy got=%h want=%h", Data_bus, 8'h01);
    end
  endtask

  task automatic test_random();
    int          k;
    bit          en, r;
    logic [15:0] a;
    logic [7:0]  wd;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) joy1 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) joy2 = 8'($urandom);
      k  = int'($urandom_range(0, 9));
      en = 1'b1;
      r  = 1'($urandom);
      wd = 8'($urandom);
      a  = 16'($urandom);
      case (k)
        0, 1, 2: begin
          a = {3'b000, a[12:0]};
          if (!m_ok[a[10:0]]) r = 1'b0;
        end
        3: begin
          a = 16'h4016; r = 1'b0;
          if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
        end
        4: begin a = 16'h4016; r = 1'b1; end
        5: begin a = 16'h4017; r = 1'b1; end
        6: begin a = 16'h4017; r = 1'b0; end
        7: a[15] = 1'b1;
        8: begin
          a = 16'(16'h2000 + $urandom_range(0, 16'h5FFF));
          if (a == 16'h4016 || a == 16'h4017) a = 16'h5000;
        end
        default: en = 1'b0;
      endcase
      do_access(en, r, a, wd);
      total++;
      if (Data_bus !== m_data) begin
        bad++; $display("FAIL random n=%0d addr=%h rw=%b en=%b got=%h want=%h", n, a, r, en, Data_bus, m_data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      m_ok[i]  = 1'b0;
      m_ram[i] = 8'h00;
    end
    model_reset();
    test_reset();
    test_ram_mirror();
    test_joy_shift();
    test_joy_strobe_live();
    test_rom_open();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
